// File: rtl/output_neuron_backprop_pkg.sv
// Shared types, limits and saturation helper for the output-neuron backward pass.
package nn_pkg;

  localparam int N_IN = 5;

  typedef logic        [9:0] act_t;
  typedef logic signed [9:0] weight_t;
  typedef logic signed [9:0] delta_t;

  localparam logic signed [23:0] W_MIN = -24'sd512;
  localparam logic signed [23:0] W_MAX = 24'sd511;

  // Intermediate results are carried at 24 bits so every product fits before clamping.
  function automatic weight_t sat10(input logic signed [23:0] v);
    if (v > W_MAX)
      return W_MAX[9:0];
    else if (v < W_MIN)
      return W_MIN[9:0];
    else
      return v[9:0];
  endfunction

endpackage

// File: rtl/output_neuron_backprop_if.sv
// Operand/result bundle between the backprop block and its controller.
interface output_neuron_backprop_if;
  import nn_pkg::*;

  logic    start;
  logic    ready;
  act_t    inVal      [N_IN];
  act_t    outVal;
  act_t    target;
  weight_t weight_in  [N_IN];
  weight_t weight_out [N_IN];
  logic    wr_en;
  logic    [2:0] wr_idx;
  weight_t wr_data;
  delta_t  delta;
  logic    done;

  modport master (
    output start, inVal, outVal, target, weight_in,
    input  ready, weight_out, wr_en, wr_idx, wr_data, delta, done
  );

  modport slave (
    input  start, inVal, outVal, target, weight_in,
    output ready, weight_out, wr_en, wr_idx, wr_data, delta, done
  );
endinterface

// File: rtl/output_neuron_backprop_weight_step.sv
// One weight update: w + ((delta * act) >>> (10 + LR_SHIFT)), saturated to 10 bits.
// Defining BP_GRAD_CLIP_EN limits each step to +/-DW_MAX before the addition.
module bp_weight_step
  import nn_pkg::*;
#(
  parameter int LR_SHIFT = 2,
  parameter int DW_MAX   = 8
) (
  input  delta_t  delta,
  input  act_t    in_val,
  input  weight_t weight,
  output weight_t new_weight
);

`ifdef BP_GRAD_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic signed [20:0] DW_HI = 21'(DW_MAX);
  localparam logic signed [20:0] DW_LO = -DW_HI;

  logic signed [20:0] prod;
  logic signed [20:0] dw;
  logic signed [20:0] dw_c;
  logic signed [23:0] sum;

  // |delta| <= 512 and act <= 1023, so the product fits in 21 signed bits.
  always_comb begin
    prod = 21'(delta) * $signed({11'b0, in_val});
    dw   = prod >>> (10 + LR_SHIFT);
    dw_c = dw;
    if (CLIP_EN) begin
      if (dw > DW_HI)
        dw_c = DW_HI;
      else if (dw < DW_LO)
        dw_c = DW_LO;
    end
    sum        = 24'(weight) + 24'(dw_c);
    new_weight = sat10(sum);
  end

endmodule

// File: rtl/output_neuron_backprop.sv
// Backward pass for the 5-input output neuron: delta, then one weight update per cycle.
// Optional BP_GRAD_CLIP_EN (see bp_weight_step) bounds each weight step.
module output_neuron_backprop
  import nn_pkg::*;
#(
  parameter int LR_SHIFT = 2,
  parameter int DW_MAX   = 8
) (
  input logic                     clk,
  input logic                     rst,
  output_neuron_backprop_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELTA  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [2:0] IDX_LAST = 3'(N_IN - 1);

  logic [1:0] state;
  logic [2:0] idx;
  act_t       in_lat [N_IN];
  weight_t    w_lat  [N_IN];
  act_t       out_lat;
  act_t       tgt_lat;
  delta_t     delta_r;
  delta_t     delta_next;
  weight_t    w_new;

  logic signed [10:0] err;
  logic        [20:0] deriv;
  logic signed [23:0] eprod;

  // Sigmoid-style derivative out*(1-out) in Q0.10 peaks at 256 for out = 0.5.
  always_comb begin
    err        = $signed({1'b0, tgt_lat}) - $signed({1'b0, out_lat});
    deriv      = (21'(out_lat) * (21'd1024 - 21'(out_lat))) >> 10;
    eprod      = 24'(err) * $signed({3'b0, deriv});
    delta_next = sat10(eprod >>> 10);
  end

  bp_weight_step #(
    .LR_SHIFT (LR_SHIFT),
    .DW_MAX   (DW_MAX)
  ) u_step (
    .delta      (delta_r),
    .in_val     (in_lat[idx]),
    .weight     (w_lat[idx]),
    .new_weight (w_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      out_lat <= '0;
      tgt_lat <= '0;
      delta_r <= '0;
      for (int k = 0; k < N_IN; k++) begin
        in_lat[k]         <= '0;
        w_lat[k]          <= '0;
        bus.weight_out[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int k = 0; k < N_IN; k++) begin
              in_lat[k] <= bus.inVal[k];
              w_lat[k]  <= bus.weight_in[k];
            end
            out_lat <= bus.outVal;
            tgt_lat <= bus.target;
            idx     <= '0;
            state   <= S_DELTA;
          end
        end
        S_DELTA: begin
          delta_r <= delta_next;
          state   <= S_UPDATE;
        end
        S_UPDATE: begin
          bus.weight_out[idx] <= w_new;
          if (idx == IDX_LAST)
            state <= S_DONE;
          else
            idx <= idx + 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The write strobe is visible in the same cycle the weight is computed.
  assign bus.ready   = (state == S_IDLE);
  assign bus.wr_en   = (state == S_UPDATE);
  assign bus.wr_idx  = bus.wr_en ? idx : 3'd0;
  assign bus.wr_data = bus.wr_en ? w_new : '0;
  assign bus.delta   = delta_r;
  assign bus.done    = (state == S_DONE);

endmodule

// File: tb/tb_output_neuron_backprop.sv
// Randomised and directed checks of output_neuron_backprop against an integer reference model.
module tb_output_neuron_backprop;
  import nn_pkg::*;

  localparam int LR_SHIFT = 2;
  localparam int DW_MAX   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  output_neuron_backprop_if bus ();

  output_neuron_backprop #(
    .LR_SHIFT (LR_SHIFT),
    .DW_MAX   (DW_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  int stim_act [N_IN];
  int stim_w   [N_IN];
  int stim_out;
  int stim_tgt;
  int exp_wout [N_IN];
  int last_wr  [N_IN];
  int last_delta;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int floor_shift(input int v, input int sh);
    int d;
    d = 1 << sh;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int model_delta(input int ov, input int tg);
    int deriv;
    deriv = (ov * (1024 - ov)) / 1024;
    return clamp(floor_shift((tg - ov) * deriv, 10), -512, 511);
  endfunction

  function automatic int model_weight(input int d, input int a, input int w);
    int dw;
    dw = floor_shift(d * a, 10 + LR_SHIFT);
`ifdef BP_GRAD_CLIP_EN
    dw = clamp(dw, -DW_MAX, DW_MAX);
`endif
    return clamp(w + dw, -512, 511);
  endfunction

  task automatic checkWeights(input string tag);
    for (int k = 0; k < N_IN; k++)
      checkOutput($sformatf("%s_wout%0d", tag, k), int'(bus.weight_out[k]), exp_wout[k]);
  endtask

  // Runs one operation from the cycle start is raised; assumes we sit just after a rising edge.
  task automatic applyStimulus(input string tag, input bit hold_start, input bit busy_pulse,
                               input int rst_at);
    int exp_d;
    int exp_w [N_IN];
    int n_strobe;
    int done_cyc;
    int ready_cyc;

    exp_d = model_delta(stim_out, stim_tgt);
    for (int k = 0; k < N_IN; k++) begin
      exp_w[k]       = model_weight(exp_d, stim_act[k], stim_w[k]);
      bus.inVal[k]     = act_t'(stim_act[k]);
      bus.weight_in[k] = weight_t'(stim_w[k]);
    end
    bus.outVal = act_t'(stim_out);
    bus.target = act_t'(stim_tgt);
    bus.start  = 1'b1;
    n_strobe   = 0;
    done_cyc   = -1;
    ready_cyc  = -1;
    @(posedge clk); #1;

    for (int c = 1; c <= 14; c++) begin
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        checkOutput({tag, "_rst_ready"}, int'(bus.ready), 1);
        checkOutput({tag, "_rst_done"}, int'(bus.done), 0);
        checkOutput({tag, "_rst_wr_en"}, int'(bus.wr_en), 0);
        for (int k = 0; k < N_IN; k++) exp_wout[k] = 0;
        checkWeights({tag, "_rst"});
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      if (c == 2) begin
        last_delta = int'(bus.delta);
        checkOutput({tag, "_delta"}, last_delta, exp_d);
      end
      if (bus.wr_en) begin
        if (n_strobe < N_IN) begin
          checkOutput($sformatf("%s_wr_idx%0d", tag, n_strobe), int'(bus.wr_idx), n_strobe);
          checkOutput($sformatf("%s_wr_data%0d", tag, n_strobe), int'(bus.wr_data),
                      exp_w[n_strobe]);
          last_wr[n_strobe] = int'(bus.wr_data);
          if (n_strobe == 0)
            checkOutput({tag, "_first_wr_cycle"}, c, 2);
        end
        n_strobe++;
      end
      if (bus.done && done_cyc < 0) done_cyc = c;
      if (bus.ready && ready_cyc < 0) ready_cyc = c;
      bus.start = (hold_start && c <= 7) || (busy_pulse && c == 3);
      @(posedge clk); #1;
    end

    checkOutput({tag, "_strobes"}, n_strobe, N_IN);
    checkOutput({tag, "_done_cycle"}, done_cyc, 7);
    checkOutput({tag, "_ready_cycle"}, ready_cyc, 8);
    for (int k = 0; k < N_IN; k++) exp_wout[k] = exp_w[k];
    checkWeights(tag);
  endtask

  task automatic setCase(input int ov, input int tg, input int a0, input int w0, input int w1);
    stim_out = ov;
    stim_tgt = tg;
    stim_act = '{a0, 1023, 0, 512, 1023};
    stim_w   = '{w0, w1, 77, -3, 300};
  endtask

  initial begin
    int exp_case1;
`ifdef BP_GRAD_CLIP_EN
    exp_case1 = 108;
`else
    exp_case1 = 115;
`endif
    bus.start = 1'b0;
    bus.outVal = '0;
    bus.target = '0;
    for (int k = 0; k < N_IN; k++) begin
      bus.inVal[k]     = '0;
      bus.weight_in[k] = '0;
      exp_wout[k]      = 0;
      last_wr[k]       = 0;
    end
    last_delta = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", int'(bus.ready), 1);
    checkOutput("reset_done", int'(bus.done), 0);
    checkOutput("reset_wr_en", int'(bus.wr_en), 0);
    checkOutput("reset_wr_idx", int'(bus.wr_idx), 0);
    checkOutput("reset_wr_data", int'(bus.wr_data), 0);
    checkOutput("reset_delta", int'(bus.delta), 0);
    checkWeights("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Positive step; idx1 starts at 510 so it hits the upper rail, idx2 has zero activation.
    setCase(512, 768, 1023, 100, 510);
    applyStimulus("pos", 1'b0, 1'b0, 0);
    checkOutput("pos_delta_const", last_delta, 64);
    checkOutput("pos_w0_const", last_wr[0], exp_case1);
    checkOutput("pos_w1_sat_hi", last_wr[1], 511);
    checkOutput("pos_w2_unchanged", last_wr[2], 77);

    // Negative step; idx1 starts at -510 so it hits the lower rail.
    setCase(768, 512, 1023, 40, -510);
    applyStimulus("neg", 1'b0, 1'b0, 0);
    checkOutput("neg_delta_const", last_delta, -48);
`ifdef BP_GRAD_CLIP_EN
    checkOutput("neg_w0_const", last_wr[0], 32);
`else
    checkOutput("neg_w0_const", last_wr[0], 28);
`endif
    checkOutput("neg_w1_sat_lo", last_wr[1], -512);

    setCase(300, 900, 700, -200, 15);
    applyStimulus("hold", 1'b1, 1'b0, 0);

    setCase(900, 100, 600, 250, -40);
    applyStimulus("busy", 1'b0, 1'b1, 0);

    setCase(512, 768, 1023, 100, 510);
    applyStimulus("midrst", 1'b0, 1'b0, 4);
    setCase(512, 768, 1023, 100, 510);
    applyStimulus("after_rst", 1'b0, 1'b0, 0);

    for (int r = 0; r < 8; r++) begin
      stim_out = int'($urandom_range(0, 1023));
      stim_tgt = int'($urandom_range(0, 1023));
      for (int k = 0; k < N_IN; k++) begin
        stim_act[k] = int'($urandom_range(0, 1023));
        stim_w[k]   = int'($urandom_range(0, 1023)) - 512;
      end
      applyStimulus($sformatf("rand%0d", r), 1'b0, 1'b0, 0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
